cluster_event_wait_ctrl: RTL and testbench
==========================================

Name: cluster_event_wait_ctrl

Overview:
- Per-core consumer of the 32-bit mapped cluster event vector.
- Latches event pulses into a sticky buffer and applies separate event and IRQ masks.
- Runs the core's wait-for-event sleep/wake handshake with core clock gating, and raises the lowest-index pending masked interrupt.
- One instance per core inside the event unit, fed by one row of the event map output.

Parameters:
NB_EVENTS, 32, width of event vector/buffer/masks
IRQ_ID_W, 5, width of IRQ id (clog2(NB_EVENTS))

Ports:
clk_i  in  1  cluster clock
rst_ni  in  1  synchronous active-low reset
events_i  in  NB_EVENTS  mapped event pulses, one-cycle, bit-per-source
evt_mask_we_i  in  1  write strobe for event mask
evt_mask_wdata_i  in  NB_EVENTS  new event mask
irq_mask_we_i  in  1  write strobe for IRQ mask
irq_mask_wdata_i  in  NB_EVENTS  new IRQ mask
buf_clr_i  in  NB_EVENTS  write-1-to-clear buffer bits, one-cycle
wait_req_i  in  1  core requests wait-for-event, one-cycle pulse
wait_clr_i  in  1  qualifies wait_req_i: clear returned bits on wake
wait_valid_o  out  1  one-cycle pulse: wait completed
wait_data_o  out  NB_EVENTS  buffer & evt_mask, valid with wait_valid_o
core_clk_en_o  out  1  core clock-gate enable
irq_req_o  out  1  masked interrupt pending
irq_id_o  out  IRQ_ID_W  lowest set index of buffer & irq_mask
irq_ack_i  in  1  core acknowledges interrupt
irq_ack_id_i  in  IRQ_ID_W  id being acknowledged
evt_buffer_o  out  NB_EVENTS  current buffer, for register readout
evt_mask_o  out  NB_EVENTS  current event mask
irq_mask_o  out  NB_EVENTS  current IRQ mask

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous, active-low, on rst_ni.
- Reset state: buffer=0, both masks=0, state=ACTIVE, core_clk_en_o=1, wait_valid_o=0, wait_data_o=0, irq_req_o=0, irq_id_o=0.
- Reset asserted mid-sleep forces ACTIVE and clk_en=1 at the next edge.
- Buffer update per edge: buf_next = (buf & ~clr_mask) | events_i.
  - clr_mask = buf_clr_i | wake_clear_bits | ack_bit.
  - Set wins over any clear on the same bit in the same cycle; no event is lost.
- Masks: written on their strobe and visible the following cycle. No other side effect.
- masked_evt = buf & evt_mask; masked_irq = buf & irq_mask. Both are combinational on registered state.
- IRQ:
  - irq_req_o = |masked_irq.
  - irq_id_o = index of lowest set bit of masked_irq; 0 when none.
  - Both are combinational from registers.
  - irq_ack_i clears bit irq_ack_id_i at the edge.
  - An ack for an id not pending is harmless; the clear is still applied.
- FSM states: ACTIVE, SLEEP, WAKE.
  - ACTIVE: clk_en=1. On wait_req_i, latch wait_clr_i into clr_flag.
    - If masked_evt!=0 this cycle, go to WAKE.
    - Else go to SLEEP.
  - SLEEP: clk_en=|masked_irq, so the core is clocked only to take an interrupt and re-gates after the ack.
    - If masked_evt!=0, go to WAKE.
    - wait_req_i is ignored.
  - WAKE (one cycle): clk_en=1, wait_valid_o=1, wait_data_o=masked_evt.
    - If clr_flag, wake_clear_bits=masked_evt.
    - Bits arriving in this same cycle survive because set wins.
    - Next state is ACTIVE.
- Latency:
  - Event pulse at edge t is in the buffer at t+1.
  - Wake cycle (WAKE, clk_en high, wait_valid_o) is at t+2 after the pulse.
  - If the event is already buffered, wait_req at cycle c gives wait_valid_o at c+1.
- Mask change during SLEEP is honoured from the next cycle. Setting a mask bit whose buffer bit is already set causes a wake.
- wait_data_o is 0 outside WAKE.
- buf_clr_i during WAKE combines with wake clear by OR.

Test Plan:
- Reset then idle → buffer=0, core_clk_en_o=1, irq_req_o=0, all mask outputs 0.
- evt_mask=0x0000_0100; wait_req_i with wait_clr_i=1; pulse events_i bit 8 two cycles later → clk_en drops the cycle after the request; wait_valid_o and clk_en=1 come two cycles after the pulse; wait_data_o=0x100; buffer bit 8 is 0 afterwards.
- Same as above but wait_clr_i=0, with event 8 already buffered → wait_valid_o the cycle after wait_req_i; buffer keeps 0x100; FSM never enters SLEEP.
- irq_mask=0x0801_0000; pulse bits 16 and 27 together → irq_req_o=1, irq_id_o=16; ack id 16 → irq_id_o=27 next cycle; ack 27 → irq_req_o=0.
- Sleeping with evt_mask=0, irq_mask=bit 11; timer event bit 11 → core_clk_en_o=1 while the irq is pending, no wait_valid_o; after the ack, clk_en returns to 0.
- events_i bit 3 pulse in the same cycle as buf_clr_i bit 3 → bit 3 stays set. Separately, rst_ni low during SLEEP → next cycle ACTIVE, clk_en=1, buffer=0.

Source files
------------

// File: rtl/cluster_event_wait_ctrl.sv
// -----------------------------------------------------------------------------
// cluster_event_wait_ctrl
//
// Per-core consumer of the mapped cluster event vector. Pulses on events_i are
// collected in a sticky buffer. Two masks select which buffered events can end
// a wait-for-event and which raise an interrupt. The block runs the core's
// sleep/wake handshake, drives the core clock-gate enable, and reports the
// lowest-index pending masked interrupt.
//
// Ports
//   clk_i, rst_ni        cluster clock, synchronous active-low reset
//   events_i             one-cycle event pulses, one bit per source
//   evt_mask_we_i/wdata  event mask write port (visible the following cycle)
//   irq_mask_we_i/wdata  IRQ mask write port (visible the following cycle)
//   buf_clr_i            write-1-to-clear strobe for buffer bits
//   wait_req_i           core asks to sleep until a masked event is pending
//   wait_clr_i           with wait_req_i: clear the returned bits on wake
//   wait_valid_o         one-cycle pulse in the wake cycle
//   wait_data_o          buffer & event mask, valid with wait_valid_o, else 0
//   core_clk_en_o        core clock-gate enable
//   irq_req_o/irq_id_o   masked interrupt pending / lowest pending index
//   irq_ack_i/ack_id_i   core acknowledges (clears) one interrupt bit
//   evt_buffer_o         current buffer contents for register readout
//   evt_mask_o           current event mask
//   irq_mask_o           current IRQ mask
// -----------------------------------------------------------------------------
module cluster_event_wait_ctrl #(
  parameter int unsigned NB_EVENTS = 32,
  parameter int unsigned IRQ_ID_W  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NB_EVENTS-1:0] events_i,
  input  logic                 evt_mask_we_i,
  input  logic [NB_EVENTS-1:0] evt_mask_wdata_i,
  input  logic                 irq_mask_we_i,
  input  logic [NB_EVENTS-1:0] irq_mask_wdata_i,
  input  logic [NB_EVENTS-1:0] buf_clr_i,
  input  logic                 wait_req_i,
  input  logic                 wait_clr_i,
  output logic                 wait_valid_o,
  output logic [NB_EVENTS-1:0] wait_data_o,
  output logic                 core_clk_en_o,
  output logic                 irq_req_o,
  output logic [IRQ_ID_W-1:0]  irq_id_o,
  input  logic                 irq_ack_i,
  input  logic [IRQ_ID_W-1:0]  irq_ack_id_i,
  output logic [NB_EVENTS-1:0] evt_buffer_o,
  output logic [NB_EVENTS-1:0] evt_mask_o,
  output logic [NB_EVENTS-1:0] irq_mask_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 clr_flag_q, clr_flag_d;

  logic [NB_EVENTS-1:0] evt_buf_q, evt_buf_d;
  logic [NB_EVENTS-1:0] evt_mask_q;
  logic [NB_EVENTS-1:0] irq_mask_q;

  logic [NB_EVENTS-1:0] masked_evt;
  logic [NB_EVENTS-1:0] masked_irq;
  logic                 evt_pending;
  logic [NB_EVENTS-1:0] wake_clear_bits;
  logic [NB_EVENTS-1:0] ack_bit;
  logic [NB_EVENTS-1:0] clr_mask;

  // ---------------------------------------------------------------------------
  // Masked views of the registered buffer
  // ---------------------------------------------------------------------------
  assign masked_evt  = evt_buf_q & evt_mask_q;
  assign masked_irq  = evt_buf_q & irq_mask_q;
  assign evt_pending = |masked_evt;

  // ---------------------------------------------------------------------------
  // Interrupt request and lowest-index priority encoder
  // ---------------------------------------------------------------------------
  assign irq_req_o = |masked_irq;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise a latch is inferred.
    irq_id_o = '0;
    // Scan from the top down so the last hit, i.e. the lowest index, wins.
    for (int i = int'(NB_EVENTS) - 1; i >= 0; i--) begin
      if (masked_irq[i]) irq_id_o = IRQ_ID_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer next value: all clear sources merge, then new events are OR-ed in
  // last so a set always beats a clear on the same bit and no pulse is lost.
  // An ack id that is out of range shifts to zero and clears nothing.
  // ---------------------------------------------------------------------------
  assign ack_bit   = irq_ack_i ? (NB_EVENTS'(1) << irq_ack_id_i) : '0;
  assign clr_mask  = buf_clr_i | wake_clear_bits | ack_bit;
  assign evt_buf_d = (evt_buf_q & ~clr_mask) | events_i;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      evt_buf_q  <= '0;
      evt_mask_q <= '0;
      irq_mask_q <= '0;
    end else begin
      evt_buf_q <= evt_buf_d;
      if (evt_mask_we_i) evt_mask_q <= evt_mask_wdata_i;
      if (irq_mask_we_i) irq_mask_q <= irq_mask_wdata_i;
    end
  end

  assign evt_buffer_o = evt_buf_q;
  assign evt_mask_o   = evt_mask_q;
  assign irq_mask_o   = irq_mask_q;

  // ---------------------------------------------------------------------------
  // Wait-for-event FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_ACTIVE;
      clr_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_flag_q <= clr_flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Wait-for-event FSM: next state
  // A request that finds a masked event already buffered skips SLEEP and
  // completes in the very next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    clr_flag_d = clr_flag_q;
    unique case (state_q)
      ST_ACTIVE: begin
        if (wait_req_i) begin
          clr_flag_d = wait_clr_i;
          state_d    = evt_pending ? ST_WAKE : ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        // A mask write that uncovers an already-buffered bit also lands here.
        if (evt_pending) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait-for-event FSM: outputs
  // While asleep the core is clocked only when an interrupt is pending, so it
  // can take the interrupt and drops back to gated after acknowledging it.
  // ---------------------------------------------------------------------------
  always_comb begin
    core_clk_en_o   = 1'b1;
    wait_valid_o    = 1'b0;
    wait_data_o     = '0;
    wake_clear_bits = '0;
    unique case (state_q)
      ST_ACTIVE: begin
        core_clk_en_o = 1'b1;
      end
      ST_SLEEP: begin
        core_clk_en_o = irq_req_o;
      end
      ST_WAKE: begin
        core_clk_en_o = 1'b1;
        wait_valid_o  = 1'b1;
        wait_data_o   = masked_evt;
        // Only the bits handed back to the core are cleared; anything arriving
        // this same cycle is re-set through the events_i term.
        if (clr_flag_q) wake_clear_bits = masked_evt;
      end
      default: begin
        core_clk_en_o = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_cluster_event_wait_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cluster_event_wait_ctrl: directed table, multi-cycle sequences,
// and a randomized run against a behavioural model of the event/wait rules.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cluster_event_wait_ctrl;

  localparam int NB = 32;
  localparam int IW = 5;

  logic          clk;
  logic          rst_ni;
  logic [NB-1:0] events;
  logic          evt_mask_we;
  logic [NB-1:0] evt_mask_wdata;
  logic          irq_mask_we;
  logic [NB-1:0] irq_mask_wdata;
  logic [NB-1:0] buf_clr;
  logic          wait_req;
  logic          wait_clr;
  logic          wait_valid;
  logic [NB-1:0] wait_data;
  logic          core_clk_en;
  logic          irq_req;
  logic [IW-1:0] irq_id;
  logic          irq_ack;
  logic [IW-1:0] irq_ack_id;
  logic [NB-1:0] evt_buffer;
  logic [NB-1:0] evt_mask;
  logic [NB-1:0] irq_mask;

  int tests_run = 0;
  int tests_failed = 0;

  cluster_event_wait_ctrl #(.NB_EVENTS(NB), .IRQ_ID_W(IW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .events_i         (events),
    .evt_mask_we_i    (evt_mask_we),
    .evt_mask_wdata_i (evt_mask_wdata),
    .irq_mask_we_i    (irq_mask_we),
    .irq_mask_wdata_i (irq_mask_wdata),
    .buf_clr_i        (buf_clr),
    .wait_req_i       (wait_req),
    .wait_clr_i       (wait_clr),
    .wait_valid_o     (wait_valid),
    .wait_data_o      (wait_data),
    .core_clk_en_o    (core_clk_en),
    .irq_req_o        (irq_req),
    .irq_id_o         (irq_id),
    .irq_ack_i        (irq_ack),
    .irq_ack_id_i     (irq_ack_id),
    .evt_buffer_o     (evt_buffer),
    .evt_mask_o       (evt_mask),
    .irq_mask_o       (irq_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    events = '0; evt_mask_we = 1'b0; evt_mask_wdata = '0;
    irq_mask_we = 1'b0; irq_mask_wdata = '0; buf_clr = '0;
    wait_req = 1'b0; wait_clr = 1'b0; irq_ack = 1'b0; irq_ack_id = '0;
  endtask

  // One-cycle stimulus record and the outputs expected after the edge.
  typedef struct {
    logic          evt_we;
    logic [NB-1:0] evt_wd;
    logic          irq_we;
    logic [NB-1:0] irq_wd;
    logic [NB-1:0] ev;
    logic [NB-1:0] clr;
    logic          ack;
    logic [IW-1:0] ack_id;
    logic [NB-1:0] x_buf;
    logic          x_req;
    logic [IW-1:0] x_id;
    logic          x_en;
    logic [NB-1:0] x_emask;
    logic [NB-1:0] x_imask;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [IW-1:0] lowest_set(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return IW'(i);
    return '0;
  endfunction

  // Behavioural model state: the core is either running, asleep awaiting a
  // masked event, or has a wake owed to it this cycle.
  logic [NB-1:0] m_buf, m_emask, m_imask;
  logic          m_asleep, m_wake_now, m_clear_on_wake;

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // Reset state
    check("rst_buf",   evt_buffer,  32'h0);
    check("rst_clken", core_clk_en, 32'h1);
    check("rst_irq",   irq_req,     32'h0);
    check("rst_id",    irq_id,      32'h0);
    check("rst_emask", evt_mask,    32'h0);
    check("rst_imask", irq_mask,    32'h0);
    check("rst_valid", wait_valid,  32'h0);
    check("rst_data",  wait_data,   32'h0);

    // ---------------- table-driven vectors (FSM stays ACTIVE) ----------------
    //          ewe ewd           iwe iwd           events        clr           ack ackid  buf           req id  en emask         imask
    vecs[0]  = '{0, 32'h0,        1, 32'h0801_0000, 32'h0,        32'h0,        0, 5'd0,  32'h0,        0, 0,  1, 32'h0,        32'h0801_0000};
    vecs[1]  = '{0, 32'h0,        0, 32'h0,        32'h0801_0000, 32'h0,        0, 5'd0,  32'h0801_0000, 1, 16, 1, 32'h0,        32'h0801_0000};
    vecs[2]  = '{0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        1, 5'd16, 32'h0800_0000, 1, 27, 1, 32'h0,        32'h0801_0000};
    vecs[3]  = '{0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        1, 5'd27, 32'h0,        0, 0,  1, 32'h0,        32'h0801_0000};
    vecs[4]  = '{0, 32'h0,        0, 32'h0,        32'h8,        32'h0,        0, 5'd0,  32'h8,        0, 0,  1, 32'h0,        32'h0801_0000};
    vecs[5]  = '{0, 32'h0,        0, 32'h0,        32'h8,        32'h8,        0, 5'd0,  32'h8,        0, 0,  1, 32'h0,        32'h0801_0000};
    vecs[6]  = '{0, 32'h0,        0, 32'h0,        32'h0,        32'h8,        0, 5'd0,  32'h0,        0, 0,  1, 32'h0,        32'h0801_0000};
    vecs[7]  = '{0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        1, 5'd5,  32'h0,        0, 0,  1, 32'h0,        32'h0801_0000};
    vecs[8]  = '{0, 32'h0,        0, 32'h0,        32'h20,       32'h0,        1, 5'd5,  32'h20,       0, 0,  1, 32'h0,        32'h0801_0000};
    vecs[9]  = '{1, 32'h100,      0, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h20,       0, 0,  1, 32'h100,      32'h0801_0000};
    vecs[10] = '{0, 32'h0,        0, 32'h0,        32'h0,        32'hFFFF_FFFF, 0, 5'd0, 32'h0,        0, 0,  1, 32'h100,      32'h0801_0000};

    for (int v = 0; v < 11; v++) begin
      evt_mask_we = vecs[v].evt_we; evt_mask_wdata = vecs[v].evt_wd;
      irq_mask_we = vecs[v].irq_we; irq_mask_wdata = vecs[v].irq_wd;
      events = vecs[v].ev; buf_clr = vecs[v].clr;
      irq_ack = vecs[v].ack; irq_ack_id = vecs[v].ack_id;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_buf", v),   evt_buffer,  vecs[v].x_buf);
      check($sformatf("vec%0d_req", v),   irq_req,     32'(vecs[v].x_req));
      check($sformatf("vec%0d_id", v),    irq_id,      32'(vecs[v].x_id));
      check($sformatf("vec%0d_en", v),    core_clk_en, 32'(vecs[v].x_en));
      check($sformatf("vec%0d_valid", v), wait_valid,  32'h0);
      check($sformatf("vec%0d_emask", v), evt_mask,    vecs[v].x_emask);
      check($sformatf("vec%0d_imask", v), irq_mask,    vecs[v].x_imask);
    end

    // ------------- sleep, wake on event 8, clear returned bits ---------------
    wait_req = 1'b1; wait_clr = 1'b1;
    tick(); idle_inputs();
    check("slp_en_drop", core_clk_en, 32'h0);
    check("slp_valid0",  wait_valid,  32'h0);
    tick();
    events = 32'h100;
    check("slp_en_still0", core_clk_en, 32'h0);
    tick(); idle_inputs();
    check("slp_buf_set",  evt_buffer,  32'h100);
    check("slp_en_pre",   core_clk_en, 32'h0);
    check("slp_valid_pre", wait_valid, 32'h0);
    tick();
    check("wake_valid", wait_valid,  32'h1);
    check("wake_en",    core_clk_en, 32'h1);
    check("wake_data",  wait_data,   32'h100);
    tick();
    check("wake_cleared",  evt_buffer,  32'h0);
    check("post_valid",    wait_valid,  32'h0);
    check("post_data",     wait_data,   32'h0);
    check("post_en",       core_clk_en, 32'h1);

    // ------------- already buffered, no clear: immediate wake ----------------
    events = 32'h100;
    tick(); idle_inputs();
    check("pre_buf", evt_buffer, 32'h100);
    wait_req = 1'b1; wait_clr = 1'b0;
    tick(); idle_inputs();
    check("fast_valid", wait_valid,  32'h1);
    check("fast_en",    core_clk_en, 32'h1);
    check("fast_data",  wait_data,   32'h100);
    tick();
    check("fast_keep_buf", evt_buffer,  32'h100);
    check("fast_valid0",   wait_valid,  32'h0);
    check("fast_en_after", core_clk_en, 32'h1);
    buf_clr = 32'h100;
    tick(); idle_inputs();
    check("fast_clr", evt_buffer, 32'h0);

    // ------------- asleep, interrupt-only wake of the core clock -------------
    evt_mask_we = 1'b1; evt_mask_wdata = 32'h0;
    irq_mask_we = 1'b1; irq_mask_wdata = 32'h800;
    tick(); idle_inputs();
    wait_req = 1'b1; wait_clr = 1'b0;
    tick(); idle_inputs();
    check("isl_en0", core_clk_en, 32'h0);
    events = 32'h800;
    tick(); idle_inputs();
    check("isl_req",    irq_req,     32'h1);
    check("isl_id",     irq_id,      32'd11);
    check("isl_en1",    core_clk_en, 32'h1);
    check("isl_valid0", wait_valid,  32'h0);
    tick();
    check("isl_en_hold", core_clk_en, 32'h1);
    irq_ack = 1'b1; irq_ack_id = 5'd11;
    tick(); idle_inputs();
    check("isl_req_gone", irq_req,     32'h0);
    check("isl_regate",   core_clk_en, 32'h0);
    check("isl_novalid",  wait_valid,  32'h0);

    // ------------- reset while asleep ----------------------------------------
    events = 32'h4;
    tick(); idle_inputs();
    check("rsl_buf4", evt_buffer,  32'h4);
    check("rsl_en0",  core_clk_en, 32'h0);
    rst_ni = 1'b0;
    tick();
    check("rsl_en1",   core_clk_en, 32'h1);
    check("rsl_buf0",  evt_buffer,  32'h0);
    check("rsl_imask", irq_mask,    32'h0);
    rst_ni = 1'b1;
    tick();
    check("rsl_active", core_clk_en, 32'h1);

    // ------------- randomized run against the behavioural model --------------
    m_buf = '0; m_emask = '0; m_imask = '0;
    m_asleep = 1'b0; m_wake_now = 1'b0; m_clear_on_wake = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NB-1:0] m_mevt, m_mirq, m_clr;
      m_mevt = m_buf & m_emask;
      m_mirq = m_buf & m_imask;

      check("rnd_buf",   evt_buffer, m_buf);
      check("rnd_emask", evt_mask,   m_emask);
      check("rnd_imask", irq_mask,   m_imask);
      check("rnd_req",   irq_req,    32'(|m_mirq));
      check("rnd_id",    irq_id,     32'(lowest_set(m_mirq)));
      check("rnd_valid", wait_valid, 32'(m_wake_now));
      check("rnd_data",  wait_data,  m_wake_now ? m_mevt : 32'h0);
      check("rnd_en",    core_clk_en, (m_asleep && !m_wake_now) ? 32'(|m_mirq) : 32'h1);

      idle_inputs();
      rst_ni = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) events = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 19) == 0) begin
        evt_mask_we = 1'b1; evt_mask_wdata = $urandom & $urandom;
      end
      if ($urandom_range(0, 19) == 0) begin
        irq_mask_we = 1'b1; irq_mask_wdata = $urandom & $urandom;
      end
      if ($urandom_range(0, 9) == 0) buf_clr = $urandom & $urandom;
      if ($urandom_range(0, 5) == 0) begin
        wait_req = 1'b1; wait_clr = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        irq_ack = 1'b1;
        irq_ack_id = ($urandom_range(0, 1) == 0) ? lowest_set(m_mirq) : IW'($urandom_range(0, NB - 1));
      end

      // Advance the model across the coming edge.
      if (!rst_ni) begin
        m_buf = '0; m_emask = '0; m_imask = '0;
        m_asleep = 1'b0; m_wake_now = 1'b0; m_clear_on_wake = 1'b0;
      end else begin
        m_clr = buf_clr;
        if (m_wake_now && m_clear_on_wake) m_clr |= m_mevt;
        if (irq_ack) m_clr[irq_ack_id] = 1'b1;
        m_buf = (m_buf & ~m_clr) | events;
        if (evt_mask_we) m_emask = evt_mask_wdata;
        if (irq_mask_we) m_imask = irq_mask_wdata;
        if (m_wake_now) begin
          m_wake_now = 1'b0;
          m_asleep   = 1'b0;
        end else if (m_asleep) begin
          if (m_mevt != 0) begin
            m_wake_now = 1'b1;
            m_asleep   = 1'b0;
          end
        end else if (wait_req) begin
          m_clear_on_wake = wait_clr;
          if (m_mevt != 0) m_wake_now = 1'b1;
          else m_asleep = 1'b1;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
